accel_arbiter: RTL and testbench
================================

ACCEL_ARBITER -- requirements
Module: accel_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requester channels (2..8).
REQ-002 Parameter WIDTH, default 256, job/result word width.
REQ-003 Parameter DEPTH, default 8, max outstanding jobs (power of 2).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, ports listed first:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
REQ-005 The block SHALL provide the following data and control ports:
- cfg_en  in  NREQ  per-channel grant enable
- req_tdata  in  NREQ*WIDTH  job data, channel i at [i*WIDTH +: WIDTH]
- req_tvalid  in  NREQ  job valid per channel
- req_tready  out  NREQ  job accepted per channel
- acc_in_tdata  out  WIDTH  job to shared accelerator
- acc_in_tvalid  out  1  job valid to accelerator
- acc_in_tready  in  1  accelerator accepts job
- acc_out_tdata  in  WIDTH  result from accelerator, in job order
- acc_out_tvalid  in  1  result valid
- acc_out_tready  out  1  result accepted
- rsp_tdata  out  WIDTH  result broadcast to all channels
- rsp_tvalid  out  NREQ  result valid, one-hot to the issuing channel
- rsp_tready  in  NREQ  channel accepts result
- outstanding  out  $clog2(DEPTH)+1  jobs issued, result not yet delivered
- err_orphan  out  1  sticky: result arrived with no outstanding job

Function
REQ-006 FSM states SHALL be IDLE and ISSUE only.
REQ-007 IDLE: if any channel has req_tvalid & cfg_en and outstanding < DEPTH, the FSM SHALL register grant = first such channel at or after rr_ptr (wrapping mod NREQ) and go to ISSUE next cycle; otherwise stay IDLE.
REQ-008 ISSUE: acc_in_tvalid SHALL be 1 and acc_in_tdata SHALL equal req_tdata of the granted channel; the grant SHALL NOT change until acc_in_tready.
REQ-009 On acc_in_tvalid & acc_in_tready: req_tready[grant] SHALL be 1 in that same cycle only; push grant into the tag FIFO; rr_ptr <= (grant+1) mod NREQ; FSM -> IDLE.
REQ-010 req_tready SHALL be 0 for all non-granted channels and in IDLE; peak throughput is one job per 2 cycles.
REQ-011 Deasserting cfg_en or req_tvalid of the granted channel during ISSUE SHALL NOT abort the issue.
REQ-012 Response path: with tag FIFO non-empty, rsp_tvalid SHALL equal acc_out_tvalid one-hot at the head tag, rsp_tdata = acc_out_tdata, acc_out_tready = rsp_tready[head]; combinational, zero latency.
REQ-013 On acc_out_tvalid & acc_out_tready with FIFO non-empty, the head tag SHALL pop.
REQ-014 With tag FIFO empty: rsp_tvalid = 0, acc_out_tready = 1 (result dropped), and err_orphan SHALL set if acc_out_tvalid.
REQ-015 outstanding SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-016 Tag FIFO pointers SHALL wrap mod DEPTH; full = (outstanding == DEPTH) blocks new grants only, never the response path.
REQ-017 err_orphan SHALL clear only on reset.

Reset
REQ-018 While rst_n is low: FSM = IDLE, rr_ptr = 0, grant = 0, tag FIFO empty, outstanding = 0, err_orphan = 0.
REQ-019 Outputs SHALL be 0 during reset (acc_out_tready = 1 because FIFO empty); in-flight tags are discarded, with no recovery.

Structure
REQ-020 Package accel_arb_pkg SHALL hold the FSM state encoding, default NREQ/WIDTH/DEPTH, and the tag width constant $clog2(NREQ).
REQ-021 The tag FIFO SHALL be one sub-module, arb_tag_fifo (synchronous, DEPTH x tag width, registered pointers, async active-low reset).

Verification
REQ-022 Single job: ch2 sends 0xA5.., acc_in_tready = 1 -> acc_in_tvalid on cycle 2, req_tready[2] pulses once, outstanding = 1; result 0x5A.. -> rsp_tvalid = 4'b0100, outstanding = 0.
REQ-023 Fairness: all 4 channels valid continuously -> grant order 0,1,2,3,0 and 4 jobs accepted in 8 cycles.
REQ-024 Backpressure and full: acc_out_tvalid held 0, ch0 streams -> 8 jobs accepted, outstanding = 8, 9th not granted; one result popped -> next grant within 2 cycles.
REQ-025 Ordering: ch1, ch3, ch1 jobs issued; rsp_tready[3] = 0 while 2nd result pending -> acc_out_tready = 0 and stalls; results delivered to 1, 3, 1 in order.
REQ-026 Orphan and mask: result with outstanding = 0 -> acc_out_tready = 1 and err_orphan = 1 sticky; cfg_en = 4'b1101 with all valid -> ch1 never granted.
REQ-027 Reset mid-operation: rst_n low with 3 outstanding during ISSUE -> all state cleared asynchronously, outstanding = 0, acc_in_tvalid = 0.

Source files
------------

// File: rtl/accel_arb_pkg.sv
// Shared definitions for the accelerator arbiter: state encoding, default
// sizing and the tag width helper.
package accel_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 256;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_TAG_W = $clog2(DEF_NREQ);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // Width of a channel tag; NREQ is at least 2 so $clog2 is never zero.
  function automatic int tag_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Tag FIFO: remembers which channel issued each outstanding job so results,
// which return in job order, can be steered back to the right requester.
module arb_tag_fifo
  import accel_arb_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [TAG_W-1:0]       push_tag,
  input  logic                   pop,
  output logic [TAG_W-1:0]       head_tag,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is only legal when a pop frees the slot that cycle.
  assign do_push  = push && (!full || do_pop);
  assign head_tag = mem[rd_ptr];
  assign count    = cnt;

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Tag storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/accel_arbiter.sv
// Round-robin arbiter sharing one in-order accelerator among NREQ requesters.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | looking for an enabled, valid channel; registers the grant
//   ST_ISSUE | presenting the granted job until the accelerator takes it
module accel_arbiter
  import accel_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          cfg_en,
  input  logic [NREQ*WIDTH-1:0]    req_tdata,
  input  logic [NREQ-1:0]          req_tvalid,
  output logic [NREQ-1:0]          req_tready,
  output logic [WIDTH-1:0]         acc_in_tdata,
  output logic                     acc_in_tvalid,
  input  logic                     acc_in_tready,
  input  logic [WIDTH-1:0]         acc_out_tdata,
  input  logic                     acc_out_tvalid,
  output logic                     acc_out_tready,
  output logic [WIDTH-1:0]         rsp_tdata,
  output logic [NREQ-1:0]          rsp_tvalid,
  input  logic [NREQ-1:0]          rsp_tready,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_orphan
);

  localparam int TAG_W = tag_width(NREQ);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] pick;
  logic             pick_vld;
  int               idx;
  logic             take_grant;
  logic             issue_fire;
  logic             rsp_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [TAG_W-1:0] head_tag;

  // Full only holds off new grants; the response path keeps draining.
  assign take_grant = (state == ST_IDLE) && pick_vld && !fifo_full;
  assign issue_fire = acc_in_tvalid && acc_in_tready;
  assign rsp_pop    = !fifo_empty && acc_out_tvalid && acc_out_tready;

  // Round-robin search: first enabled, valid channel at or after rr_ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_vld && req_tvalid[idx[TAG_W-1:0]] && cfg_en[idx[TAG_W-1:0]]) begin
        pick     = TAG_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; once in ISSUE only the accelerator handshake leaves it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take_grant)    state_nxt = ST_ISSUE;
      ST_ISSUE: if (acc_in_tready) state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Grant is latched on entry to ISSUE; the pointer moves past it on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      if (take_grant) grant <= pick;
      if (issue_fire) rr_ptr <= (int'(grant) == NREQ-1) ? '0 : grant + TAG_W'(1);
    end
  end

  // FSM outputs: present the granted job and echo the accept to that channel.
  always_comb begin
    acc_in_tvalid = (state == ST_ISSUE);
    acc_in_tdata  = '0;
    req_tready    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state == ST_ISSUE) && (grant == TAG_W'(i))) begin
        acc_in_tdata  = req_tdata[i*WIDTH +: WIDTH];
        req_tready[i] = acc_in_tready;
      end
    end
  end

  // Result steering to the head tag; with nothing outstanding results are sunk.
  always_comb begin
    rsp_tvalid     = '0;
    rsp_tdata      = '0;
    acc_out_tready = 1'b1;
    if (!fifo_empty) begin
      rsp_tdata = acc_out_tdata;
      for (int i = 0; i < NREQ; i++) begin
        if (head_tag == TAG_W'(i)) begin
          rsp_tvalid[i]  = acc_out_tvalid;
          acc_out_tready = rsp_tready[i];
        end
      end
    end
  end

  // Sticky flag for a result that no job is waiting for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_orphan <= 1'b0;
    else if (fifo_empty && acc_out_tvalid) err_orphan <= 1'b1;
  end

  arb_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue_fire),
    .push_tag (grant),
    .pop      (rsp_pop),
    .head_tag (head_tag),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (outstanding)
  );

endmodule

// File: tb/tb_accel_arbiter.sv
// Bench for accel_arbiter: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_accel_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 256;
  localparam int DEPTH = 8;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       cfg_en;
  logic [NREQ*WIDTH-1:0] req_tdata;
  logic [NREQ-1:0]       req_tvalid;
  logic [NREQ-1:0]       req_tready;
  logic [WIDTH-1:0]      acc_in_tdata;
  logic                  acc_in_tvalid;
  logic                  acc_in_tready;
  logic [WIDTH-1:0]      acc_out_tdata;
  logic                  acc_out_tvalid;
  logic                  acc_out_tready;
  logic [WIDTH-1:0]      rsp_tdata;
  logic [NREQ-1:0]       rsp_tvalid;
  logic [NREQ-1:0]       rsp_tready;
  logic [OW-1:0]         outstanding;
  logic                  err_orphan;

  int errors = 0;
  int checks = 0;

  // Reference model: pending grant (-1 = none), round-robin pointer, tag queue.
  int m_grant;
  int m_rr;
  int m_tags[$];
  bit m_orphan;

  logic             exp_in_valid;
  logic [WIDTH-1:0] exp_in_data;
  logic [NREQ-1:0]  exp_req_ready;
  logic [NREQ-1:0]  exp_rsp_valid;
  logic             exp_out_ready;
  int               exp_outstanding;
  logic             exp_orphan;

  accel_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_en         (cfg_en),
    .req_tdata      (req_tdata),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .acc_in_tdata   (acc_in_tdata),
    .acc_in_tvalid  (acc_in_tvalid),
    .acc_in_tready  (acc_in_tready),
    .acc_out_tdata  (acc_out_tdata),
    .acc_out_tvalid (acc_out_tvalid),
    .acc_out_tready (acc_out_tready),
    .rsp_tdata      (rsp_tdata),
    .rsp_tvalid     (rsp_tvalid),
    .rsp_tready     (rsp_tready),
    .outstanding    (outstanding),
    .err_orphan     (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < WIDTH/32; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] chan_data(input int c);
    return req_tdata[c*WIDTH +: WIDTH];
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_grant = -1;
    m_rr    = 0;
    m_tags.delete();
    m_orphan = 1'b0;
  endtask

  // Expected outputs for the current model state and current inputs.
  task automatic model_outputs();
    exp_in_valid  = (m_grant >= 0);
    exp_in_data   = (m_grant >= 0) ? chan_data(m_grant) : '0;
    exp_req_ready = '0;
    if (m_grant >= 0 && acc_in_tready) exp_req_ready[m_grant] = 1'b1;
    exp_rsp_valid = '0;
    exp_out_ready = 1'b1;
    if (m_tags.size() > 0) begin
      exp_rsp_valid[m_tags[0]] = acc_out_tvalid;
      exp_out_ready = rsp_tready[m_tags[0]];
    end
    exp_outstanding = m_tags.size();
    exp_orphan      = m_orphan;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    int occ;
    int nxt;
    bit found;
    int c;
    occ   = m_tags.size();
    nxt   = m_grant;
    found = 1'b0;
    if (occ > 0 && acc_out_tvalid && rsp_tready[m_tags[0]]) void'(m_tags.pop_front());
    if (occ == 0 && acc_out_tvalid) m_orphan = 1'b1;
    if (m_grant >= 0) begin
      if (acc_in_tready) begin
        m_tags.push_back(m_grant);
        m_rr = (m_grant + 1) % NREQ;
        nxt  = -1;
      end
    end else if (occ < DEPTH) begin
      for (int i = 0; i < NREQ; i++) begin
        c = (m_rr + i) % NREQ;
        if (!found && req_tvalid[c] && cfg_en[c]) begin
          nxt   = c;
          found = 1'b1;
        end
      end
    end
    m_grant = nxt;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_defaults();
    cfg_en         = '1;
    req_tvalid     = '0;
    req_tdata      = '0;
    acc_in_tready  = 1'b0;
    acc_out_tvalid = 1'b0;
    acc_out_tdata  = '0;
    rsp_tready     = '1;
  endtask

  task automatic apply_reset();
    drive_defaults();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Offer one job on channel c and wait (bounded) until it is accepted.
  task automatic issue_job(input int c, input logic [WIDTH-1:0] d, output bit ok);
    ok = 1'b0;
    req_tdata[c*WIDTH +: WIDTH] = d;
    req_tvalid    = '0;
    req_tvalid[c] = 1'b1;
    acc_in_tready = 1'b1;
    for (int n = 0; n < 8 && !ok; n++) begin
      #1;
      if (req_tready[c]) ok = 1'b1;
      tick();
    end
    req_tvalid    = '0;
    acc_in_tready = 1'b0;
  endtask

  task automatic test_reset();
    drive_defaults();
    rst_n = 1'b0;
    model_reset();
    req_tvalid    = '1;
    acc_in_tready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (acc_in_tvalid !== 1'b0) begin errors++; $display("FAIL reset_acc_in_tvalid got=%b exp=0", acc_in_tvalid); end
    checks++; if (req_tready !== '0) begin errors++; $display("FAIL reset_req_tready got=%b exp=0000", req_tready); end
    checks++; if (rsp_tvalid !== '0) begin errors++; $display("FAIL reset_rsp_tvalid got=%b exp=0000", rsp_tvalid); end
    checks++; if (acc_out_tready !== 1'b1) begin errors++; $display("FAIL reset_acc_out_tready got=%b exp=1", acc_out_tready); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
    drive_defaults();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_job();
    int pulses;
    logic [WIDTH-1:0] job;
    logic [WIDTH-1:0] res;
    job = {(WIDTH/8){8'hA5}};
    res = {(WIDTH/8){8'h5A}};
    pulses = 0;
    apply_reset();
    req_tdata[2*WIDTH +: WIDTH] = job;
    req_tvalid[2]  = 1'b1;
    acc_in_tready  = 1'b1;
    #1;
    checks++; if (acc_in_tvalid !== 1'b0) begin errors++; $display("FAIL single_cycle1_tvalid got=%b exp=0", acc_in_tvalid); end
    if (req_tready != '0) pulses++;
    tick();
    #1;
    checks++; if (acc_in_tvalid !== 1'b1) begin errors++; $display("FAIL single_cycle2_tvalid got=%b exp=1", acc_in_tvalid); end
    checks++; if (acc_in_tdata !== job) begin errors++; $display("FAIL single_tdata got=%h exp=%h", acc_in_tdata, job); end
    checks++; if (req_tready !== 4'b0100) begin errors++; $display("FAIL single_req_tready got=%b exp=0100", req_tready); end
    if (req_tready != '0) pulses++;
    tick();
    req_tvalid = '0;
    for (int n = 0; n < 3; n++) begin
      #1;
      if (req_tready != '0) pulses++;
      tick();
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulse_count got=%0d exp=1", pulses); end
    checks++; if (outstanding !== OW'(1)) begin errors++; $display("FAIL single_outstanding1 got=%0d exp=1", outstanding); end
    acc_out_tdata  = res;
    acc_out_tvalid = 1'b1;
    #1;
    checks++; if (rsp_tvalid !== 4'b0100) begin errors++; $display("FAIL single_rsp_tvalid got=%b exp=0100", rsp_tvalid); end
    checks++; if (rsp_tdata !== res) begin errors++; $display("FAIL single_rsp_tdata got=%h exp=%h", rsp_tdata, res); end
    tick();
    acc_out_tvalid = 1'b0;
    #1;
    checks++; if (outstanding !== OW'(0)) begin errors++; $display("FAIL single_outstanding0 got=%0d exp=0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL single_no_orphan got=%b exp=0", err_orphan); end
  endtask

  task automatic test_fairness();
    int order[$];
    int in8;
    int c;
    apply_reset();
    for (int i = 0; i < NREQ; i++) req_tdata[i*WIDTH +: WIDTH] = {(WIDTH/8){8'(i + 1)}};
    req_tvalid    = '1;
    acc_in_tready = 1'b1;
    in8 = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      #1;
      if (req_tready != '0) begin
        c = onehot_idx(req_tready);
        order.push_back(c);
        if (cyc <= 8) in8++;
        checks++; if (acc_in_tdata !== chan_data(c)) begin errors++; $display("FAIL fair_tdata ch=%0d got=%h exp=%h", c, acc_in_tdata, chan_data(c)); end
      end
      tick();
    end
    checks++; if (in8 !== 4) begin errors++; $display("FAIL fair_jobs_in_8 got=%0d exp=4", in8); end
    checks++;
    if (order.size() < 5) begin
      errors++; $display("FAIL fair_order_len got=%0d exp>=5", order.size());
    end else if (order[0] !== 0 || order[1] !== 1 || order[2] !== 2 || order[3] !== 3 || order[4] !== 0) begin
      errors++; $display("FAIL fair_order got=%0d,%0d,%0d,%0d,%0d exp=0,1,2,3,0", order[0], order[1], order[2], order[3], order[4]);
    end
    req_tvalid = '0;
  endtask

  task automatic test_full();
    int accepted;
    bit regrant;
    apply_reset();
    req_tdata[0 +: WIDTH] = rand_word();
    req_tvalid[0] = 1'b1;
    acc_in_tready = 1'b1;
    accepted = 0;
    for (int n = 0; n < 24; n++) begin
      #1;
      if (req_tready[0]) accepted++;
      tick();
    end
    #1;
    checks++; if (accepted !== DEPTH) begin errors++; $display("FAIL full_accepted got=%0d exp=%0d", accepted, DEPTH); end
    checks++; if (outstanding !== OW'(DEPTH)) begin errors++; $display("FAIL full_outstanding got=%0d exp=%0d", outstanding, DEPTH); end
    checks++; if (acc_in_tvalid !== 1'b0) begin errors++; $display("FAIL full_no_ninth got=%b exp=0", acc_in_tvalid); end
    acc_out_tdata  = rand_word();
    acc_out_tvalid = 1'b1;
    #1;
    checks++; if (acc_out_tready !== 1'b1) begin errors++; $display("FAIL full_out_tready got=%b exp=1", acc_out_tready); end
    checks++; if (rsp_tvalid !== 4'b0001) begin errors++; $display("FAIL full_rsp_tvalid got=%b exp=0001", rsp_tvalid); end
    tick();
    acc_out_tvalid = 1'b0;
    regrant = 1'b0;
    for (int n = 0; n < 2 && !regrant; n++) begin
      #1;
      if (req_tready[0]) regrant = 1'b1;
      tick();
    end
    checks++; if (regrant !== 1'b1) begin errors++; $display("FAIL full_regrant_within_2 got=%b exp=1", regrant); end
    #1;
    checks++; if (outstanding !== OW'(DEPTH)) begin errors++; $display("FAIL full_refill got=%0d exp=%0d", outstanding, DEPTH); end
    req_tvalid = '0;
  endtask

  task automatic test_ordering();
    bit ok;
    logic [WIDTH-1:0] r;
    apply_reset();
    issue_job(1, rand_word(), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL order_issue_a got=%b exp=1", ok); end
    issue_job(3, rand_word(), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL order_issue_b got=%b exp=1", ok); end
    issue_job(1, rand_word(), ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL order_issue_c got=%b exp=1", ok); end
    #1;
    checks++; if (outstanding !== OW'(3)) begin errors++; $display("FAIL order_outstanding got=%0d exp=3", outstanding); end
    r = rand_word();
    acc_out_tdata  = r;
    acc_out_tvalid = 1'b1;
    rsp_tready     = '1;
    #1;
    checks++; if (rsp_tvalid !== 4'b0010) begin errors++; $display("FAIL order_first got=%b exp=0010", rsp_tvalid); end
    checks++; if (rsp_tdata !== r) begin errors++; $display("FAIL order_first_data got=%h exp=%h", rsp_tdata, r); end
    tick();
    acc_out_tdata = rand_word();
    rsp_tready    = 4'b0111;
    #1;
    checks++; if (rsp_tvalid !== 4'b1000) begin errors++; $display("FAIL order_second got=%b exp=1000", rsp_tvalid); end
    checks++; if (acc_out_tready !== 1'b0) begin errors++; $display("FAIL order_stall got=%b exp=0", acc_out_tready); end
    tick();
    tick();
    #1;
    checks++; if (outstanding !== OW'(2)) begin errors++; $display("FAIL order_stalled_outstanding got=%0d exp=2", outstanding); end
    rsp_tready = '1;
    #1;
    checks++; if (acc_out_tready !== 1'b1) begin errors++; $display("FAIL order_release got=%b exp=1", acc_out_tready); end
    tick();
    #1;
    checks++; if (rsp_tvalid !== 4'b0010) begin errors++; $display("FAIL order_third got=%b exp=0010", rsp_tvalid); end
    tick();
    acc_out_tvalid = 1'b0;
    #1;
    checks++; if (outstanding !== OW'(0)) begin errors++; $display("FAIL order_drained got=%0d exp=0", outstanding); end
  endtask

  task automatic test_orphan_mask();
    int cnt[NREQ];
    apply_reset();
    acc_out_tdata  = rand_word();
    acc_out_tvalid = 1'b1;
    #1;
    checks++; if (acc_out_tready !== 1'b1) begin errors++; $display("FAIL orphan_out_tready got=%b exp=1", acc_out_tready); end
    checks++; if (rsp_tvalid !== '0) begin errors++; $display("FAIL orphan_rsp_tvalid got=%b exp=0000", rsp_tvalid); end
    tick();
    acc_out_tvalid = 1'b0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got=%b exp=1", err_orphan); end
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    cfg_en         = 4'b1101;
    req_tvalid     = '1;
    acc_in_tready  = 1'b1;
    acc_out_tvalid = 1'b1;
    for (int n = 0; n < 24; n++) begin
      #1;
      for (int i = 0; i < NREQ; i++) if (req_tready[i]) cnt[i]++;
      tick();
    end
    checks++; if (cnt[1] !== 0) begin errors++; $display("FAIL mask_ch1_granted got=%0d exp=0", cnt[1]); end
    checks++; if (cnt[0] + cnt[2] + cnt[3] !== 12) begin errors++; $display("FAIL mask_total got=%0d exp=12", cnt[0] + cnt[2] + cnt[3]); end
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got=%b exp=1", err_orphan); end
    drive_defaults();
  endtask

  task automatic test_reset_mid();
    bit reached;
    apply_reset();
    req_tvalid    = '1;
    acc_in_tready = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < 12 && !reached; n++) begin
      #1;
      if (outstanding == OW'(3)) reached = 1'b1;
      else tick();
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("FAIL midrst_reach3 got=%b exp=1", reached); end
    acc_in_tready = 1'b0;
    tick();
    #1;
    checks++; if (acc_in_tvalid !== 1'b1) begin errors++; $display("FAIL midrst_in_issue got=%b exp=1", acc_in_tvalid); end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (outstanding !== OW'(0)) begin errors++; $display("FAIL midrst_outstanding got=%0d exp=0", outstanding); end
    checks++; if (acc_in_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid got=%b exp=0", acc_in_tvalid); end
    checks++; if (acc_out_tready !== 1'b1) begin errors++; $display("FAIL midrst_out_tready got=%b exp=1", acc_out_tready); end
    drive_defaults();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    #1;
    checks++; if (outstanding !== OW'(0)) begin errors++; $display("FAIL midrst_no_recovery got=%0d exp=0", outstanding); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      cfg_en = ($urandom_range(0, 3) == 0) ? NREQ'($urandom()) : '1;
      req_tvalid = NREQ'($urandom());
      for (int c = 0; c < NREQ; c++) req_tdata[c*WIDTH +: WIDTH] = rand_word();
      acc_in_tready  = ($urandom_range(0, 3) != 0);
      acc_out_tvalid = ($urandom_range(0, 2) == 0);
      acc_out_tdata  = rand_word();
      rsp_tready     = NREQ'($urandom());
      #1;
      model_outputs();
      checks++; if (acc_in_tvalid !== exp_in_valid) begin errors++; $display("FAIL rnd_acc_in_tvalid cyc=%0d got=%b exp=%b", n, acc_in_tvalid, exp_in_valid); end
      if (exp_in_valid) begin
        checks++; if (acc_in_tdata !== exp_in_data) begin errors++; $display("FAIL rnd_acc_in_tdata cyc=%0d got=%h exp=%h", n, acc_in_tdata, exp_in_data); end
      end
      checks++; if (req_tready !== exp_req_ready) begin errors++; $display("FAIL rnd_req_tready cyc=%0d got=%b exp=%b", n, req_tready, exp_req_ready); end
      checks++; if (rsp_tvalid !== exp_rsp_valid) begin errors++; $display("FAIL rnd_rsp_tvalid cyc=%0d got=%b exp=%b", n, rsp_tvalid, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        checks++; if (rsp_tdata !== acc_out_tdata) begin errors++; $display("FAIL rnd_rsp_tdata cyc=%0d got=%h exp=%h", n, rsp_tdata, acc_out_tdata); end
      end
      checks++; if (acc_out_tready !== exp_out_ready) begin errors++; $display("FAIL rnd_acc_out_tready cyc=%0d got=%b exp=%b", n, acc_out_tready, exp_out_ready); end
      checks++; if (int'(outstanding) !== exp_outstanding) begin errors++; $display("FAIL rnd_outstanding cyc=%0d got=%0d exp=%0d", n, outstanding, exp_outstanding); end
      checks++; if (err_orphan !== exp_orphan) begin errors++; $display("FAIL rnd_err_orphan cyc=%0d got=%b exp=%b", n, err_orphan, exp_orphan); end
      tick();
    end
    drive_defaults();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_defaults();
    model_reset();
    test_reset();
    test_single_job();
    test_fairness();
    test_full();
    test_ordering();
    test_orphan_mask();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
